// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage.
// Keeps a small FIFO of {address, instruction} pairs filled from instruction memory.
// At most one memory request is outstanding at a time.
// A taken branch flushes the FIFO and redirects fetch. A response that was already
// in flight when the branch arrived is discarded when it returns.
module if_prefetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [ADDR_W-1:0]          branch_addr,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_ack,
  input  logic [INST_W-1:0]          mem_rdata,
  output logic [INST_W-1:0]          instruction,
  output logic [ADDR_W-1:0]          PC,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

  // Registered state
  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [INST_W-1:0] inst_mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_req_r;
  logic              discard_r;

  // Next-state signals
  logic              pop_s;
  logic              push_s;
  logic              hold_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [ADDR_W-1:0] fetch_pc_nxt_s;
  logic [ADDR_W-1:0] mem_addr_nxt_s;
  logic              mem_req_nxt_s;
  logic              discard_nxt_s;

  assign count       = count_r;
  assign valid       = (count_r != '0);
  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign instruction = inst_mem_r[rd_ptr_r];
  assign PC          = addr_mem_r[rd_ptr_r] + STEP_C;

  // Next-state logic: FIFO occupancy, pointers, discard flag and request issue.
  always_comb begin
    pop_s          = valid && !freeze && !branch_taken;
    push_s         = mem_req_r && mem_ack && !discard_r && !branch_taken;
    hold_s         = mem_req_r && !mem_ack;
    count_nxt_s    = count_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    fetch_pc_nxt_s = fetch_pc_r;
    mem_addr_nxt_s = mem_addr_r;
    mem_req_nxt_s  = mem_req_r;
    discard_nxt_s  = discard_r;

    // A branch flushes the FIFO and suppresses any push or pop in the same cycle.
    if (branch_taken) begin
      count_nxt_s    = '0;
      rd_ptr_nxt_s   = '0;
      wr_ptr_nxt_s   = '0;
      fetch_pc_nxt_s = branch_addr;
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (push_s && !pop_s) begin
        count_nxt_s = count_r + CNT_W'(1);
      end else if (pop_s && !push_s) begin
        count_nxt_s = count_r - CNT_W'(1);
      end else begin
        count_nxt_s = count_r;
      end
    end

    // An unacknowledged request holds mem_req and mem_addr.
    // A branch arriving during that wait marks the response for discard.
    // Otherwise a new request is issued whenever the FIFO will still have room.
    if (hold_s) begin
      if (branch_taken) begin
        discard_nxt_s = 1'b1;
      end else begin
        discard_nxt_s = discard_r;
      end
    end else begin
      discard_nxt_s = 1'b0;
      if (count_nxt_s < DEPTH_C) begin
        mem_req_nxt_s  = 1'b1;
        mem_addr_nxt_s = fetch_pc_nxt_s;
        fetch_pc_nxt_s = fetch_pc_nxt_s + STEP_C;
      end else begin
        mem_req_nxt_s  = 1'b0;
      end
    end
  end

  // State register with synchronous reset; the FIFO storage is cleared on reset as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= '0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      fetch_pc_r <= RESET_PC;
      mem_addr_r <= RESET_PC;
      mem_req_r  <= 1'b0;
      discard_r  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= '0;
        inst_mem_r[i] <= '0;
      end
    end else begin
      count_r    <= count_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      mem_addr_r <= mem_addr_nxt_s;
      mem_req_r  <= mem_req_nxt_s;
      discard_r  <= discard_nxt_s;
      if (push_s) begin
        addr_mem_r[wr_ptr_r] <= mem_addr_r;
        inst_mem_r[wr_ptr_r] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed self-checking bench for if_prefetch_stage (default parameters).
// The memory returns data equal to the request address.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic [31:0] PC;
  logic        valid;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  if_prefetch_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(instruction),
    .PC(PC), .valid(valid), .count(count)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then release. On return the first request (address 0) is out and the FIFO is empty.
  task automatic do_reset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0; mem_ack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0; mem_ack = 1'b0;
    tick(); tick();
    n_cmp++; if (count !== 3'd0)     begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (valid !== 1'b0)     begin n_bad++; $display("FAIL reset_valid got %0b want 0", valid); end
    n_cmp++; if (mem_req !== 1'b0)   begin n_bad++; $display("FAIL reset_req got %0b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    rst = 1'b0;
    #2;
    n_cmp++; if (mem_req !== 1'b0)   begin n_bad++; $display("FAIL rel_cycle1_req got %0b want 0", mem_req); end
    tick();
    n_cmp++; if (mem_req !== 1'b1)   begin n_bad++; $display("FAIL rel_cycle2_req got %0b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rel_cycle2_addr got %h want 0", mem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    mem_ack = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++; if (mem_addr !== 32'(4*k))        begin n_bad++; $display("FAIL stream_addr[%0d] got %h want %h", k, mem_addr, 32'(4*k)); end
      n_cmp++; if (count !== 3'd1)               begin n_bad++; $display("FAIL stream_count[%0d] got %0d want 1", k, count); end
      n_cmp++; if (instruction !== 32'(4*(k-1))) begin n_bad++; $display("FAIL stream_inst[%0d] got %h want %h", k, instruction, 32'(4*(k-1))); end
      n_cmp++; if (PC !== 32'(4*k))              begin n_bad++; $display("FAIL stream_pc[%0d] got %h want %h", k, PC, 32'(4*k)); end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_freeze();
    do_reset();
    freeze = 1'b1; mem_ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (count !== 3'(k)) begin n_bad++; $display("FAIL freeze_fill[%0d] got %0d want %0d", k, count, k); end
    end
    n_cmp++; if (mem_req !== 1'b0)         begin n_bad++; $display("FAIL freeze_full_req got %0b want 0", mem_req); end
    tick(); tick();
    n_cmp++; if (count !== 3'd4)           begin n_bad++; $display("FAIL freeze_hold_count got %0d want 4", count); end
    n_cmp++; if (mem_req !== 1'b0)         begin n_bad++; $display("FAIL freeze_hold_req got %0b want 0", mem_req); end
    n_cmp++; if (instruction !== 32'h0)    begin n_bad++; $display("FAIL freeze_head_inst got %h want 0", instruction); end
    n_cmp++; if (PC !== 32'h4)             begin n_bad++; $display("FAIL freeze_head_pc got %h want 4", PC); end
    freeze = 1'b0;
    tick();
    freeze = 1'b1;
    n_cmp++; if (count !== 3'd3)           begin n_bad++; $display("FAIL unfreeze_count got %0d want 3", count); end
    n_cmp++; if (mem_req !== 1'b1)         begin n_bad++; $display("FAIL unfreeze_req got %0b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h10)      begin n_bad++; $display("FAIL unfreeze_addr got %h want 10", mem_addr); end
    n_cmp++; if (instruction !== 32'h4)    begin n_bad++; $display("FAIL unfreeze_inst got %h want 4", instruction); end
    tick();
    n_cmp++; if (count !== 3'd4)           begin n_bad++; $display("FAIL refill_count got %0d want 4", count); end
    n_cmp++; if (mem_req !== 1'b0)         begin n_bad++; $display("FAIL refill_req got %0b want 0", mem_req); end
    mem_ack = 1'b0; freeze = 1'b0;
  endtask

  task automatic test_branch_pending();
    do_reset();
    freeze = 1'b1; mem_ack = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (count !== 3'd3)           begin n_bad++; $display("FAIL bp_pre_count got %0d want 3", count); end
    mem_ack = 1'b0; branch_taken = 1'b1; branch_addr = 32'h100;
    tick();
    branch_taken = 1'b0;
    n_cmp++; if (count !== 3'd0)           begin n_bad++; $display("FAIL bp_flush_count got %0d want 0", count); end
    n_cmp++; if (mem_req !== 1'b1)         begin n_bad++; $display("FAIL bp_hold_req got %0b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'hC)       begin n_bad++; $display("FAIL bp_hold_addr got %h want c", mem_addr); end
    mem_ack = 1'b1;
    tick();
    n_cmp++; if (count !== 3'd0)           begin n_bad++; $display("FAIL bp_discard_count got %0d want 0", count); end
    n_cmp++; if (valid !== 1'b0)           begin n_bad++; $display("FAIL bp_discard_valid got %0b want 0", valid); end
    n_cmp++; if (mem_addr !== 32'h100)     begin n_bad++; $display("FAIL bp_target_addr got %h want 100", mem_addr); end
    tick();
    n_cmp++; if (valid !== 1'b1)           begin n_bad++; $display("FAIL bp_first_valid got %0b want 1", valid); end
    n_cmp++; if (PC !== 32'h104)           begin n_bad++; $display("FAIL bp_first_pc got %h want 104", PC); end
    n_cmp++; if (instruction !== 32'h100)  begin n_bad++; $display("FAIL bp_first_inst got %h want 100", instruction); end
    mem_ack = 1'b0; freeze = 1'b0;
  endtask

  task automatic test_double_branch();
    do_reset();
    mem_ack = 1'b0; branch_taken = 1'b1; branch_addr = 32'h100;
    tick();
    branch_addr = 32'h200;
    tick();
    branch_taken = 1'b0;
    n_cmp++; if (mem_addr !== 32'h0)       begin n_bad++; $display("FAIL db_hold_addr got %h want 0", mem_addr); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_cmp++; if (count !== 3'd0)           begin n_bad++; $display("FAIL db_discard_count got %0d want 0", count); end
    n_cmp++; if (mem_addr !== 32'h200)     begin n_bad++; $display("FAIL db_target_addr got %h want 200", mem_addr); end
  endtask

  task automatic test_branch_ack();
    do_reset();
    freeze = 1'b1; mem_ack = 1'b1;
    tick(); tick();
    n_cmp++; if (count !== 3'd2)           begin n_bad++; $display("FAIL ba_pre_count got %0d want 2", count); end
    branch_taken = 1'b1; branch_addr = 32'h40;
    tick();
    branch_taken = 1'b0;
    n_cmp++; if (count !== 3'd0)           begin n_bad++; $display("FAIL ba_count got %0d want 0", count); end
    n_cmp++; if (mem_req !== 1'b1)         begin n_bad++; $display("FAIL ba_req got %0b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h40)      begin n_bad++; $display("FAIL ba_addr got %h want 40", mem_addr); end
    tick();
    n_cmp++; if (instruction !== 32'h40)   begin n_bad++; $display("FAIL ba_head_inst got %h want 40", instruction); end
    n_cmp++; if (PC !== 32'h44)            begin n_bad++; $display("FAIL ba_head_pc got %h want 44", PC); end
    mem_ack = 1'b0; freeze = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    freeze = 1'b1; mem_ack = 1'b1;
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    n_cmp++; if (mem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_first_addr got %h want fffffffc", mem_addr); end
    tick();
    n_cmp++; if (mem_addr !== 32'h0)         begin n_bad++; $display("FAIL wrap_addr got %h want 0", mem_addr); end
    n_cmp++; if (instruction !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_inst got %h want fffffffc", instruction); end
    n_cmp++; if (PC !== 32'h0)               begin n_bad++; $display("FAIL wrap_pc got %h want 0", PC); end
    tick();
    n_cmp++; if (mem_addr !== 32'h4)         begin n_bad++; $display("FAIL wrap_next_addr got %h want 4", mem_addr); end
    n_cmp++; if (count !== 3'd2)             begin n_bad++; $display("FAIL wrap_count got %0d want 2", count); end
    mem_ack = 1'b0; freeze = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    freeze = 1'b1; mem_ack = 1'b1;
    tick(); tick();
    mem_ack = 1'b0;
    tick();
    n_cmp++; if (count !== 3'd2)           begin n_bad++; $display("FAIL rm_pre_count got %0d want 2", count); end
    rst = 1'b1; mem_ack = 1'b1; branch_taken = 1'b1; branch_addr = 32'h300;
    tick();
    branch_taken = 1'b0;
    n_cmp++; if (count !== 3'd0)           begin n_bad++; $display("FAIL rm_count got %0d want 0", count); end
    n_cmp++; if (valid !== 1'b0)           begin n_bad++; $display("FAIL rm_valid got %0b want 0", valid); end
    n_cmp++; if (mem_req !== 1'b0)         begin n_bad++; $display("FAIL rm_req got %0b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0)       begin n_bad++; $display("FAIL rm_addr got %h want 0", mem_addr); end
    rst = 1'b0;
    tick();
    n_cmp++; if (count !== 3'd0)           begin n_bad++; $display("FAIL rm_late_ack_count got %0d want 0", count); end
    n_cmp++; if (mem_addr !== 32'h0)       begin n_bad++; $display("FAIL rm_restart_addr got %h want 0", mem_addr); end
    tick();
    n_cmp++; if (count !== 3'd1)           begin n_bad++; $display("FAIL rm_restart_count got %0d want 1", count); end
    mem_ack = 1'b0; freeze = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_freeze();
    test_branch_pending();
    test_double_branch();
    test_branch_ack();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_prefetch_stage.md
IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC, branch and memory addresses.
REQ-002 Parameter INST_W, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, prefetch buffer entries; power of 2 and at least 2.
REQ-004 Parameter PC_STEP, default 4, address increment per instruction.
REQ-005 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-006 The block SHALL have a single clock and reset (already decided):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-007 The block SHALL have the following ports:
- freeze  in  1  consumer stall; while high, the head entry is not popped.
- branch_taken  in  1  redirect fetch; flush the buffer.
- branch_addr  in  ADDR_W  redirect target.
- mem_req  out  1  registered instruction-memory request.
- mem_addr  out  ADDR_W  registered request address.
- mem_ack  in  1  memory response strobe; meaningful only while mem_req=1.
- mem_rdata  in  INST_W  response data, valid with mem_ack.
- instruction  out  INST_W  head-entry instruction.
- PC  out  ADDR_W  head-entry address + PC_STEP.
- valid  out  1  the head entry is valid (buffer not empty).
- count  out  clog2(DEPTH)+1  buffer occupancy.

Function
REQ-008 The block SHALL hold a FIFO of DEPTH {address, instruction} entries; valid=(count!=0); instruction/PC SHALL be driven from the head entry, with PC = entry address + PC_STEP modulo 2^ADDR_W.
REQ-009 Pop SHALL occur at an edge where valid=1, freeze=0 and branch_taken=0.
REQ-010 Push SHALL occur at an edge where mem_req=1, mem_ack=1, discard=0 and branch_taken=0; the entry is {mem_addr, mem_rdata}.
REQ-011 Simultaneous push and pop SHALL leave count unchanged; the pushed entry becomes visible as head at the earliest the cycle after the edge, and there is no combinational bypass.
REQ-012 At most one request SHALL be outstanding; while mem_req=1 and mem_ack=0, mem_req and mem_addr SHALL hold, regardless of freeze or branch.
REQ-013 A new request SHALL be issued, with mem_req rising or staying high next cycle, only when no request is pending after the edge and count_next < DEPTH; the FIFO therefore never overflows.
REQ-014 On issuing a request, mem_addr SHALL load fetch_pc, and fetch_pc SHALL advance by PC_STEP with wrap-around modulo 2^ADDR_W.
REQ-015 Back-to-back: on an ack edge with space remaining, mem_req SHALL stay high and mem_addr SHALL advance by PC_STEP, sustaining one instruction per cycle.
REQ-016 Branch, highest priority, at an edge with branch_taken=1:
- count<=0 (flush);
- fetch_pc<=branch_addr;
- any concurrent pop or push is suppressed.
REQ-017 Branch with no request pending, or with a pending request acked in the same cycle: the response is dropped, and next cycle mem_req=1 with mem_addr=branch_addr.
REQ-018 Branch with a request pending and not acked: set discard=1 and keep mem_req/mem_addr. On the later ack, drop the data, clear discard, and next cycle issue mem_addr=branch target.
REQ-019 A second branch while discard=1 SHALL retarget fetch_pc only; discard remains set.
REQ-020 freeze SHALL NOT stop prefetch; prefetch stops only when the buffer is full.
REQ-021 The block SHALL have no combinational path from mem_ack, freeze or branch_taken to mem_req or mem_addr.

Reset
REQ-022 While rst=1 at an edge, the block SHALL set:
- count=0, valid=0, mem_req=0, discard=0;
- fetch_pc=RESET_PC, mem_addr=RESET_PC.
REQ-023 Reset SHALL override branch, ack and freeze in the same cycle; an in-flight response is abandoned, and an ack arriving after reset with mem_req=0 is ignored.
REQ-024 In the first cycle after rst falls, mem_req=0; in the second cycle, mem_req=1 with mem_addr=RESET_PC.

Verification
REQ-025 Reset release, memory acks every cycle, freeze=0, and data = address:
- mem_addr sequence 0,4,8,...;
- instruction stream 0,4,8,... with PC 4,8,12,...
REQ-026 freeze held high, memory always acks:
- count rises to 4;
- mem_req then stays 0, and the head stays instruction 0 / PC 4;
- after releasing freeze for one cycle, count=3 and mem_req rises next cycle.
REQ-027 count=3 with a request pending and not acked; branch_addr=0x100 pulsed:
- count=0 next cycle and the discard ack is not pushed;
- the next issued mem_addr is 0x100, and the first valid head has PC 0x104.
REQ-028 Branch asserted in the same cycle as an ack at count=2:
- ack data dropped, count=0;
- next cycle mem_req=1, mem_addr=branch_addr.
REQ-029 Fetch stream starting at fetch_pc=2^ADDR_W-4:
- mem_addr wraps to 0;
- the head PC for address 2^ADDR_W-4 reads 0.
REQ-030 rst asserted mid-stream with count=2 and a request pending:
- next cycle count=0, valid=0, mem_req=0;
- a late mem_ack does not push.
